// File: rtl/vec_norm_if.sv
// vec_norm_if: start/done request and result bundle for vec_norm_unit.
interface vec_norm_if;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] xn;
  logic [31:0] yn;
  logic [31:0] mag;
  logic        busy;
  logic        done;
  modport master (output start, x, y, input xn, yn, mag, busy, done);
  modport slave  (input start, x, y, output xn, yn, mag, busy, done);
endinterface

// File: rtl/vec_norm_unit.sv
// vec_norm_unit: sequential Q16.16 2-D vector normalizer (square, bit-serial sqrt, two shared divisions).
module vec_norm_unit #(
  parameter int ITER_SQRT = 32,
  parameter int ITER_DIV  = 17
) (
  input logic       clk,
  input logic       rst_n,
  vec_norm_if.slave v
);
  typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIVX, DIVY} state_t;
  state_t      state, state_d;
  logic [4:0]  cnt;
  logic [31:0] xs, ys, ax, ay, root, rem, xq, xn_r, yn_r, mag_r;
  logic [63:0] m2;
  logic [33:0] r;
  logic [16:0] dq, dv, dq_n;
  logic [35:0] s_sh, s_trial, s_diff;
  logic [32:0] d_sh, d_diff;
  logic [31:0] q_s;
  logic        s_ge, d_ge, zero, last_sqrt, last_div, fin, done_r;
  always_comb begin
    ax = xs[31] ? -xs : xs;
    ay = ys[31] ? -ys : ys;
    s_sh = {r, m2[63:62]};
    s_trial = {2'b00, root, 2'b01};
    s_ge = s_sh >= s_trial;
    s_diff = s_sh - s_trial;
    d_sh = {rem, dv[16]};
    d_ge = d_sh >= {1'b0, root};
    d_diff = d_sh - {1'b0, root};
    dq_n = {dq[15:0], d_ge};
    q_s = ((state == DIVX) ? xs[31] : ys[31]) ? -{15'b0, dq_n} : {15'b0, dq_n};
    zero = root == 32'd0;
    last_sqrt = cnt == 5'(ITER_SQRT - 1);
    last_div = cnt == 5'(ITER_DIV - 1);
    state_d = state;
    case (state)
      IDLE:    state_d = v.start ? SQUARE : IDLE;
      SQUARE:  state_d = SQRT;
      SQRT:    state_d = last_sqrt ? DIVX : SQRT;
      DIVX:    state_d = zero ? IDLE : (last_div ? DIVY : DIVX);
      DIVY:    state_d = last_div ? IDLE : DIVY;
      default: state_d = IDLE;
    endcase
    fin = (state == DIVX && zero) || (state == DIVY && last_div);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= (state_d != state) ? 5'd0 : cnt + 5'd1;
    end
  // Root doubles as the divisor once SQRT finishes; rem/dq/dv are the one divider reused for x then y.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xs <= '0;
      ys <= '0;
      m2 <= '0;
      r <= '0;
      root <= '0;
      rem <= '0;
      dq <= '0;
      dv <= '0;
      xq <= '0;
      xn_r <= '0;
      yn_r <= '0;
      mag_r <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= fin;
      case (state)
        IDLE: if (v.start) begin
          xs <= v.x;
          ys <= v.y;
        end
        SQUARE: begin
          m2 <= {32'b0, ax} * {32'b0, ax} + {32'b0, ay} * {32'b0, ay};
          r <= '0;
          root <= '0;
        end
        SQRT: begin
          m2 <= {m2[61:0], 2'b00};
          r <= s_ge ? s_diff[33:0] : s_sh[33:0];
          root <= {root[30:0], s_ge};
          if (last_sqrt) begin
            rem <= {1'b0, ax[31:1]};
            dv <= {ax[0], 16'b0};
          end
        end
        DIVX: if (zero) begin
          xn_r <= '0;
          yn_r <= '0;
          mag_r <= '0;
        end else if (last_div) begin
          xq <= q_s;
          dq <= dq_n;
          rem <= {1'b0, ay[31:1]};
          dv <= {ay[0], 16'b0};
        end else begin
          rem <= d_ge ? d_diff[31:0] : d_sh[31:0];
          dq <= dq_n;
          dv <= {dv[15:0], 1'b0};
        end
        DIVY: begin
          rem <= d_ge ? d_diff[31:0] : d_sh[31:0];
          dq <= dq_n;
          dv <= {dv[15:0], 1'b0};
          if (last_div) begin
            xn_r <= xq;
            yn_r <= q_s;
            mag_r <= root;
          end
        end
        default: ;
      endcase
    end
  assign v.busy = state != IDLE;
  assign v.done = done_r;
  assign v.xn = xn_r;
  assign v.yn = yn_r;
  assign v.mag = mag_r;
endmodule
